multicycle_ctrl: RTL

- Main FSM for the multi-cycle datapath; sequences one instruction over 3-5 cycles.
- Drives the 4-bit aluOp bus consumed by aluControl, plus the datapath mux selects and write strobes.
- Handshakes with a unified instruction/data memory that may stall.

---
 rtl/multicycle_if.sv | 43 ++++
 rtl/multicycle_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_if.sv
// Control/status bundle between multicycle_ctrl (master) and the datapath (slave).
// PERF_CNT_EN adds the instrCount/stallCount performance counters.
interface multicycle_if;
  logic [3:0]  opcode;
  logic        zero;
  logic        memReady;
  logic [3:0]  aluOp;
  logic        aluSrcA;
  logic [1:0]  aluSrcB;
  logic        iorD;
  logic        memRead;
  logic        memWrite;
  logic        irWrite;
  logic        pcWrite;
  logic [1:0]  pcSrc;
  logic        regWrite;
  logic        regDst;
  logic        memToReg;
  logic        halted;
  logic [3:0]  state;
`ifdef PERF_CNT_EN
  logic [31:0] instrCount;
  logic [31:0] stallCount;
`endif

  modport master (
    input  opcode, zero, memReady,
    output aluOp, aluSrcA, aluSrcB, iorD, memRead, memWrite, irWrite, pcWrite,
           pcSrc, regWrite, regDst, memToReg, halted, state
`ifdef PERF_CNT_EN
    , output instrCount, stallCount
`endif
  );

  modport slave (
    output opcode, zero, memReady,
    input  aluOp, aluSrcA, aluSrcB, iorD, memRead, memWrite, irWrite, pcWrite,
           pcSrc, regWrite, regDst, memToReg, halted, state
`ifdef PERF_CNT_EN
    , input instrCount, stallCount
`endif
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle datapath: sequences one instruction over 3-5 cycles.
// Optional PERF_CNT_EN adds retired-instruction and memory-stall counters.
module multicycle_ctrl #(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  multicycle_if.master bus
);

  localparam int unsigned OP_W  = 4;
  localparam int unsigned ST_W  = 4;
  localparam int unsigned CNT_W = 32;

  localparam logic [OP_W-1:0] OP_R    = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADDI = 4'b0001;
  localparam logic [OP_W-1:0] OP_ANDI = 4'b0010;
  localparam logic [OP_W-1:0] OP_ORI  = 4'b0011;
  localparam logic [OP_W-1:0] OP_SUBI = 4'b0100;
  localparam logic [OP_W-1:0] OP_JMP  = 4'b0101;
  localparam logic [OP_W-1:0] OP_LHW  = 4'b0111;
  localparam logic [OP_W-1:0] OP_SHW  = 4'b1000;
  localparam logic [OP_W-1:0] OP_BEQ  = 4'b1001;
  localparam logic [OP_W-1:0] OP_BNE  = 4'b1010;

  localparam logic [OP_W-1:0] ALU_ADD = 4'b0001;

  typedef enum logic [ST_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_WB_R     = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  state_t          state_q, state_d;
  logic [OP_W-1:0] op_q;

  logic [OP_W-1:0] alu_op_c;
  logic            alu_src_a_c;
  logic [1:0]      alu_src_b_c;
  logic            iord_c;
  logic            mem_read_c;
  logic            mem_write_c;
  logic            ir_write_c;
  logic            pc_write_c;
  logic [1:0]      pc_src_c;
  logic            reg_write_c;
  logic            reg_dst_c;
  logic            mem_to_reg_c;
  logic            halted_c;

  // State register; the opcode is captured in DECODE so later states ignore the IR input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= bus.opcode;
      end
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_d      = state_q;
    alu_op_c     = '0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 2'd0;
    iord_c       = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    pc_src_c     = 2'd0;
    reg_write_c  = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    halted_c     = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read_c  = 1'b1;
        alu_src_b_c = 2'd1;
        alu_op_c    = ALU_ADD;
        ir_write_c  = bus.memReady;
        pc_write_c  = bus.memReady;
        if (bus.memReady) begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Speculative branch target PC + imm lands in ALUOut.
        alu_src_b_c = 2'd2;
        alu_op_c    = ALU_ADD;
        case (bus.opcode)
          OP_R:                              state_d = S_EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SUBI: state_d = S_EXEC_I;
          OP_LHW, OP_SHW:                    state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
          OP_JMP:                            state_d = S_JUMP;
          default:                           state_d = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = OP_R;
        state_d     = S_WB_R;
      end
      S_EXEC_I: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'd2;
        alu_op_c    = op_q;
        state_d     = S_WB_I;
      end
      S_WB_R: begin
        reg_write_c = 1'b1;
        reg_dst_c   = 1'b1;
        state_d     = S_FETCH;
      end
      S_WB_I: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'd2;
        alu_op_c    = (op_q == OP_SHW) ? OP_SHW : OP_LHW;
        state_d     = (op_q == OP_SHW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read_c = 1'b1;
        iord_c     = 1'b1;
        if (bus.memReady) begin
          state_d = S_WB_MEM;
        end
      end
      S_MEM_WR: begin
        mem_write_c = 1'b1;
        iord_c      = 1'b1;
        if (bus.memReady) begin
          state_d = S_FETCH;
        end
      end
      S_WB_MEM: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = op_q;
        pc_src_c    = 2'd1;
        pc_write_c  = ((op_q == OP_BEQ) && bus.zero) || ((op_q == OP_BNE) && !bus.zero);
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_src_c   = 2'd2;
        pc_write_c = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT: begin
        halted_c = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Outputs are forced low while reset is held so no strobe survives an abort.
  assign bus.aluOp    = rst ? alu_op_c    : '0;
  assign bus.aluSrcA  = rst & alu_src_a_c;
  assign bus.aluSrcB  = rst ? alu_src_b_c : 2'd0;
  assign bus.iorD     = rst & iord_c;
  assign bus.memRead  = rst & mem_read_c;
  assign bus.memWrite = rst & mem_write_c;
  assign bus.irWrite  = rst & ir_write_c;
  assign bus.pcWrite  = rst & pc_write_c;
  assign bus.pcSrc    = rst ? pc_src_c    : 2'd0;
  assign bus.regWrite = rst & reg_write_c;
  assign bus.regDst   = rst & reg_dst_c;
  assign bus.memToReg = rst & mem_to_reg_c;
  assign bus.halted   = rst & halted_c;
  assign bus.state    = rst ? ST_W'(state_q) : '0;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] instr_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;

  // Retired instructions count re-entries to FETCH; stalls count memReady=0 memory cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if ((state_q != S_FETCH) && (state_d == S_FETCH)) begin
        instr_cnt_q <= instr_cnt_q + CNT_W'(1);
      end
      if (((state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR)) &&
          !bus.memReady) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.instrCount = instr_cnt_q;
  assign bus.stallCount = stall_cnt_q;
`endif

endmodule
